// File: rtl/ifetch_pc_unit.sv
// ifetch_pc_unit: KGP-RISC PC register, imem fetch handshake, next-PC selection and link write.
module ifetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [4:0]  opcode,
  output logic [4:0]  funccode,
  input  logic        ex_done,
  input  logic [2:0]  branch,
  input  logic        brLink,
  input  logic [31:0] rs_val,
  input  logic        flag_carry,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic [31:0] instr_count,
  output logic        halted
);
  typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, cnt_q, cnt_d, next_pc, target;
  logic        arm_q, arm_d, wait_q, wait_d, accept, retire, br2_taken, br3_taken, taken;
  assign imem_req    = state_q == S_FETCH && arm_q;
  assign imem_addr   = pc_q;
  assign instr_valid = state_q == S_ISSUE;
  assign halted      = state_q == S_HALT;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:27];
  assign funccode    = instr_q[4:0];
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign link_addr   = pc_q + 32'(PC_STEP);
  assign retire      = state_q == S_ISSUE && ex_done;
  assign link_we     = retire && brLink;
  // wait_q keeps a response from being taken in the first cycle the request is up
  assign accept      = imem_req && wait_q && imem_valid;
  always_comb begin
    br2_taken = !funccode[2] && (!funccode[1] || (funccode[0] ^ flag_carry));
    br3_taken = funccode[1:0] == 2'b00 ? rs_val[31] :
                funccode[1:0] == 2'b01 ? rs_val == 32'd0 :
                funccode[1:0] == 2'b10 ? rs_val != 32'd0 : 1'b0;
    taken     = branch == 3'b001 || (branch == 3'b010 && br2_taken) || (branch == 3'b100 && br3_taken);
    target    = (branch == 3'b001 ? rs_val : {5'b0, instr_q[26:0]}) & ~32'd3;
    next_pc   = taken ? target : link_addr;
    arm_d     = 1'b1;
    wait_d    = imem_req && !accept;
    instr_d   = accept ? imem_rdata : instr_q;
    pc_d      = retire ? next_pc : pc_q;
    cnt_d     = cnt_q + 32'(retire);
    state_d   = accept ? S_ISSUE : retire ? (halt ? S_HALT : S_FETCH) : state_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= 32'd0;
      arm_q   <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      wait_q  <= wait_d;
    end
  end
endmodule

// File: tb/tb_ifetch_pc_unit.sv
// tb_ifetch_pc_unit: randomized fetch/issue traffic checked against a branch-rule reference model.
module tb_ifetch_pc_unit;
  logic        clk = 0, rst_n = 0, imem_valid = 0, ex_done = 0, brLink = 0, flag_carry = 0, halt = 0;
  logic [31:0] imem_rdata = 0, rs_val = 0;
  logic [2:0]  branch = 0;
  logic        imem_req, instr_valid, link_we, halted;
  logic [31:0] imem_addr, instr, pc, link_addr, instr_count;
  logic [4:0]  opcode, funccode;
  int          checks = 0, errors = 0;
  logic [31:0] m_pc = 0, m_cnt = 0, m_instr = 0;

  ifetch_pc_unit dut (
    .clk(clk), .rst(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr), .opcode(opcode),
    .funccode(funccode), .ex_done(ex_done), .branch(branch), .brLink(brLink), .rs_val(rs_val),
    .flag_carry(flag_carry), .halt(halt), .pc(pc), .link_we(link_we), .link_addr(link_addr),
    .instr_count(instr_count), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic [31:0] rs, input logic [2:0] br, input logic c);
    bit tk;
    tk = 0;
    case (br)
      3'b001: return {rs[31:2], 2'b00};
      3'b010: case (ins[2:0])
                3'd0, 3'd1: tk = 1;
                3'd2:       tk = c;
                3'd3:       tk = !c;
                default:    tk = 0;
              endcase
      3'b100: case (ins[1:0])
                2'd0:    tk = rs[31];
                2'd1:    tk = (rs == 0);
                2'd2:    tk = (rs != 0);
                default: tk = 0;
              endcase
      default: tk = 0;
    endcase
    return tk ? {5'b0, ins[26:2], 2'b00} : cur + 32'd4;
  endfunction

  task automatic check_reset_state();
    chk("rst_req", imem_req, 0);
    chk("rst_ivalid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_link_we", link_we, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_instr", instr, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1;
    imem_valid = 1;
    imem_rdata = $urandom;
    #1 chk("rel_req_low", imem_req, 0);
    @(negedge clk);
    imem_valid = 0;
    chk("rel_ignored", instr_valid, 0);
    chk("rel_req_up", imem_req, 1);
  endtask

  task automatic fetch(input logic [31:0] word, input int extra);
    int n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      chk("req_timeout", 0, 1);
      return;
    end
    chk("imem_addr", imem_addr, m_pc);
    imem_valid = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    @(negedge clk);
    chk("no_accept_first", instr_valid, 0);
    imem_valid = 0;
    repeat (extra) begin
      @(negedge clk);
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, m_pc);
    end
    imem_valid = 1;
    imem_rdata = word;
    @(negedge clk);
    imem_valid = 0;
    imem_rdata = $urandom;
    m_instr = word;
    chk("instr_valid", instr_valid, 1);
    chk("instr", instr, word);
    chk("opcode", opcode, word[31:27]);
    chk("funccode", funccode, word[4:0]);
    chk("req_low", imem_req, 0);
  endtask

  task automatic issue(input logic [2:0] br, input logic bl, input logic [31:0] rs,
                       input logic c, input logic h, input int idle);
    logic [31:0] exp_pc;
    repeat (idle) begin
      branch = 3'($urandom);
      brLink = 1'($urandom);
      rs_val = $urandom;
      flag_carry = 1'($urandom);
      halt = 1'($urandom);
      imem_valid = 1'($urandom);
      @(negedge clk);
      chk("issue_hold", instr_valid, 1);
      chk("instr_hold", instr, m_instr);
      chk("cnt_hold", instr_count, m_cnt);
      chk("pc_hold", pc, m_pc);
    end
    imem_valid = 0;
    branch = br; brLink = bl; rs_val = rs; flag_carry = c; halt = h; ex_done = 1;
    #1;
    chk("link_we", link_we, bl);
    chk("link_addr", link_addr, m_pc + 32'd4);
    exp_pc = ref_next(m_pc, m_instr, rs, br, c);
    @(negedge clk);
    ex_done = 0; brLink = 0; halt = 0;
    m_pc = exp_pc;
    m_cnt++;
    chk("pc", pc, m_pc);
    chk("instr_count", instr_count, m_cnt);
    chk("link_we_pulse", link_we, 0);
    chk("halted", halted, h);
    chk("ivalid_off", instr_valid, 0);
  endtask

  initial begin
    logic [2:0]  br;
    logic [31:0] rs;
    #3 check_reset_state();
    @(negedge clk);
    release_reset();
    fetch(32'h0800_0000, 0);
    chk("t1_opcode", opcode, 5'b00001);
    issue(3'b000, 0, $urandom, 0, 0, 1);
    chk("t1_pc", pc, 32'd4);
    fetch($urandom, 1);
    issue(3'b001, 0, 32'h40, 0, 0, 0);
    fetch(32'h0000_0101, 0);
    issue(3'b010, 1, $urandom, 0, 0, 0);
    chk("t2_pc", pc, 32'h100);
    fetch(32'h0000_2002, 0);
    issue(3'b010, 0, $urandom, 0, 0, 0);
    fetch(32'h0000_2002, 2);
    issue(3'b010, 0, $urandom, 1, 0, 0);
    chk("t3_pc", pc, 32'h2000);
    fetch($urandom, 0);
    issue(3'b001, 0, 32'h0000_0207, 0, 0, 0);
    chk("t4_br1", pc, 32'h204);
    fetch(32'h0000_0401, 0);
    issue(3'b100, 0, 0, 0, 0, 0);
    fetch(32'h0000_0802, 0);
    issue(3'b100, 0, 0, 0, 0, 0);
    chk("t4_bnz", pc, 32'h404);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: br = 3'b000;
        1: br = 3'b001;
        2: br = 3'b010;
        3: br = 3'b100;
        default: br = 3'($urandom);
      endcase
      rs = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      fetch($urandom, $urandom_range(0, 3));
      issue(br, 1'($urandom), rs, 1'($urandom), 0, $urandom_range(0, 2));
    end
    chk("req_mid", imem_req, 1);
    #2 rst_n = 0;
    m_pc = 0;
    m_cnt = 0;
    #1 check_reset_state();
    release_reset();
    fetch($urandom, 0);
    issue(3'b001, 0, 32'hFFFF_FFFF, 0, 0, 0);
    fetch($urandom & 32'hFFFF_FFE0 | 32'h8, 0);
    issue(3'b000, 0, $urandom, 0, 0, 0);
    chk("wrap_pc", pc, 32'd0);
    fetch(32'h0000_0300, 0);
    issue(3'b010, 0, $urandom, 0, 1, 0);
    chk("halt_pc", pc, 32'h300);
    repeat (4) begin
      ex_done = 1;
      imem_valid = 1'($urandom);
      @(negedge clk);
      chk("halt_stay", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_ivalid", instr_valid, 0);
      chk("halt_cnt", instr_count, m_cnt);
      chk("halt_pc_hold", pc, m_pc);
    end
    ex_done = 0;
    imem_valid = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ifetch_pc_unit.md
Name: ifetch_pc_unit

Overview:
- Instruction-fetch and next-PC stage of the KGP-RISC single-issue core.
- Holds the PC and fetches one 32-bit word from instruction memory through a req/valid handshake.
- Presents the instruction and its opcode/funccode fields to the Control decoder.
- Consumes the resolved branch/brLink control and the operands from execute to select the next PC and drive the link-register write.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment for sequential PC

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address, equal to pc
imem_valid  in  1  read data valid
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/opcode/funccode valid for decode/execute
instr  out  32  held instruction register
opcode  out  5  instr[31:27]
funccode  out  5  instr[4:0]
ex_done  in  1  single-cycle pulse: current instruction completed
branch  in  3  one-hot branch class from Control: 001 BR1, 010 BR2, 100 BR3, 000 none
brLink  in  1  link request from Control
rs_val  in  32  rs operand from register file
flag_carry  in  1  ALU carry flag
halt  in  1  stop after the current instruction
pc  out  32  current PC
link_we  out  1  one-cycle link-register write strobe
link_addr  out  32  return address, pc+PC_STEP
instr_count  out  32  retired-instruction counter
halted  out  1  core halted

Behaviour:
- Reset (rst=0, asynchronous): state=S_FETCH, pc=RESET_PC, instr=0, instr_count=0.
- Reset forces instr_valid, link_we, halted and imem_req to 0 immediately.
- Reset mid-fetch abandons the outstanding request. Any imem_valid seen in the first cycle after release is ignored.
- imem_req is asserted from the second cycle after release.
- FSM states: S_FETCH, S_ISSUE, S_HALT.
- S_FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_valid.
  - On imem_valid, instr<=imem_rdata and the FSM moves to S_ISSUE.
  - imem_valid is never accepted in the same cycle imem_req first rises. Minimum fetch latency is 2 cycles.
- S_ISSUE:
  - instr_valid=1 and imem_req=0. instr is held constant.
  - Remains in S_ISSUE until ex_done=1.
- On ex_done in S_ISSUE:
  - instr_count increments, wrapping at 2^32.
  - pc loads next_pc.
  - Go to S_HALT if halt=1, otherwise S_FETCH.
- ex_done in any other state is ignored, with no counter or pc change. imem_valid outside S_FETCH is ignored.
- next_pc is pc+PC_STEP (mod 2^32) unless taken:
  - BR1: always taken, target=rs_val.
  - BR2: funccode[2:0]=000 b, 001 bl, 010 bcy, 011 bncy. 000/001 always taken. 010 taken if flag_carry=1. 011 taken if flag_carry=0. 1xx not taken.
  - BR3: funccode[1:0]=00 bltz (rs_val[31]=1), 01 bz (rs_val==0), 10 bnz (rs_val!=0). 11 not taken.
  - BR2/BR3 target={5'b0, instr[26:0]}.
  - Every target has bits [1:0] forced to 00.
  - branch values that are not one-hot: not taken.
- link_addr is combinational pc+PC_STEP.
- link_we=1 for exactly the ex_done cycle when brLink=1, independent of the taken decision.
- S_HALT: halted=1, imem_req=0, instr_valid=0. Exit only via reset.
- ex_done together with halt on a taken branch: pc still updates to the target before halting.

Test Plan:
1. Reset release, imem_valid 2 cycles after req with rdata=32'h0800_0000 -> imem_addr=0 during fetch; instr_valid=1, opcode=00001; ex_done -> pc=4, instr_count=1.
2. pc=0x40, BR2 funccode=001 (bl), instr[26:0]=0x100, ex_done -> link_we pulse, link_addr=0x44, next imem_addr=0x100.
3. BR2 bcy, flag_carry=0 -> pc=pc+4; repeat with flag_carry=1 -> pc=instr[26:0]&~3.
4. BR1 with rs_val=0x0000_0207 -> pc=0x204. BR3 bz with rs_val=0 -> taken; BR3 bnz with rs_val=0 -> pc+4.
5. Assert rst low while imem_req=1, mid-fetch -> imem_req, instr_valid, halted drop asynchronously; pc=RESET_PC; imem_valid pulse in the first cycle after release ignored.
6. pc=32'hFFFF_FFFC, non-branch ex_done -> pc wraps to 0. halt=1 with ex_done -> halted=1, no further imem_req, later ex_done pulses ignored (instr_count unchanged).
